// File: rtl/ifetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus the
// decode handoff channel. The fetch unit is the master on both.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    output if_pc,
    output if_inst,
    input  if_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    input  if_pc,
    input  if_inst,
    output if_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word, waits for the
// response, holds it for decode, then advances or follows a redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  ifetch_unit_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic        req_q;
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc       = pc + 32'd4;

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = pc_q;
  assign bus.if_inst   = inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= redirect_tgt;
          state <= REQ;
          req_q <= 1'b1;
        end

        REQ: begin
          if (redirect) pc <= redirect_tgt;
          // A redirect coinciding with the grant leaves that response orphaned.
          if (bus.imem_gnt) begin
            state <= WAIT;
            req_q <= 1'b0;
            kill  <= redirect;
          end
        end

        WAIT: begin
          if (redirect) pc <= redirect_tgt;
          if (bus.imem_rvalid) begin
            kill <= 1'b0;
            if (kill || redirect) begin
              state <= REQ;
              req_q <= 1'b1;
            end else begin
              pc_q    <= pc;
              inst_q  <= bus.imem_rdata;
              state   <= HOLD;
              valid_q <= 1'b1;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end

        HOLD: begin
          // Redirect wins over the sequential increment; a same-cycle
          // transfer is still consumed by decode.
          if (redirect || bus.if_ready) begin
            pc      <= redirect ? redirect_tgt : pc_inc;
            state   <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a behavioural memory answers grants, and
// expected grant addresses and decode transfers are queued ahead of stimulus.
module tb_ifetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } xfer_t;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr[$];
  xfer_t       exp_xfer[$];

  logic        gnt_en   = 1'b0;
  logic        ready_en = 1'b0;
  logic        stray_rv = 1'b0;
  int          lat      = 1;
  logic        pend     = 1'b0;
  int          cnt      = 0;
  logic [31:0] pend_data;
  int          cyc      = 0;
  int          last_gnt = 0;
  int          prev_gnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // One clock: drive memory/decode/redirect at negedge, score handshakes that
  // will complete on the coming edge, then return just after that edge.
  task automatic tick(input logic rd, input logic [31:0] rpc);
    logic [31:0] ea;
    xfer_t       ex;
    @(negedge clk);
    cyc++;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend_data;
        pend            = 1'b0;
      end
    end else if (stray_rv) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_0BAD;
    end
    stray_rv     = 1'b0;
    bus.imem_gnt = gnt_en;
    bus.if_ready = ready_en;
    redirect     = rd;
    redirect_pc  = rpc;
    if (bus.imem_req && bus.imem_gnt) begin
      ea = (exp_addr.size() != 0) ? exp_addr.pop_front() : ~bus.imem_addr;
      check_val("gnt_addr", bus.imem_addr, ea);
      pend      = 1'b1;
      cnt       = lat;
      pend_data = mem_fn(bus.imem_addr);
      prev_gnt  = last_gnt;
      last_gnt  = cyc;
    end
    if (bus.if_valid && bus.if_ready) begin
      if (exp_xfer.size() != 0) ex = exp_xfer.pop_front();
      else begin
        ex.pc   = ~bus.if_pc;
        ex.inst = ~bus.if_inst;
      end
      check_val("xfer_pc", bus.if_pc, ex.pc);
      check_val("xfer_inst", bus.if_inst, ex.inst);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] a);
    lat      = 1;
    ready_en = 1'b1;
    exp_addr.push_back(a);
    exp_xfer.push_back('{a, mem_fn(a)});
    gnt_en = 1'b1;
    for (int i = 0; i < 20 && exp_addr.size() != 0; i++) tick(1'b0, 32'h0);
    gnt_en = 1'b0;
    check_val("fetch_gnt_to", exp_addr.size(), 0);
    for (int i = 0; i < 20 && exp_xfer.size() != 0; i++) tick(1'b0, 32'h0);
    check_val("fetch_xfer_to", exp_xfer.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_req"}, bus.imem_req, 0);
    check_val({tag, "_addr"}, bus.imem_addr, 32'h0);
    check_val({tag, "_valid"}, bus.if_valid, 0);
    check_val({tag, "_pc"}, bus.if_pc, 32'h0);
    check_val({tag, "_inst"}, bus.if_inst, 32'h0000_0013);
  endtask

  initial begin
    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.if_ready    = 1'b0;

    // Reset state, then basic fetch with 3-cycle cadence.
    gnt_en   = 1'b1;
    ready_en = 1'b1;
    lat      = 1;
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    check_reset_vals("rst");
    exp_addr.push_back(32'h0);
    exp_xfer.push_back('{32'h0, 32'h0010_0093});
    exp_addr.push_back(32'h4);
    rst_n = 1'b1;
    tick(1'b0, 32'h0);
    check_val("idle_to_req", bus.imem_req, 1);
    check_val("first_addr", bus.imem_addr, 32'h0);
    for (int i = 0; i < 20 && exp_addr.size() != 0; i++) tick(1'b0, 32'h0);
    check_val("s1_gnt_to", exp_addr.size(), 0);
    check_val("s1_xfer_to", exp_xfer.size(), 0);
    check_val("period", last_gnt - prev_gnt, 3);
    gnt_en   = 1'b0;
    ready_en = 1'b0;

    // Stall in HOLD for 5 cycles; a stray rvalid must not disturb it.
    for (int i = 0; i < 10 && !bus.if_valid; i++) tick(1'b0, 32'h0);
    check_val("s2_hold", bus.if_valid, 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) stray_rv = 1'b1;
      tick(1'b0, 32'h0);
      check_val("stall_valid", bus.if_valid, 1);
      check_val("stall_pc", bus.if_pc, 32'h4);
      check_val("stall_inst", bus.if_inst, mem_fn(32'h4));
      check_val("stall_req", bus.imem_req, 0);
    end
    exp_xfer.push_back('{32'h4, mem_fn(32'h4)});
    ready_en = 1'b1;
    tick(1'b0, 32'h0);
    check_val("s2_xfer", exp_xfer.size(), 0);

    // Redirect while waiting: response discarded, refetch at aligned target.
    lat = 3;
    exp_addr.push_back(32'h8);
    gnt_en = 1'b1;
    for (int i = 0; i < 10 && exp_addr.size() != 0; i++) tick(1'b0, 32'h0);
    gnt_en = 1'b0;
    check_val("s3_gnt_to", exp_addr.size(), 0);
    tick(1'b1, 32'h0000_0102);
    check_val("s3_valid0", bus.if_valid, 0);
    check_val("s3_req0", bus.imem_req, 0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 32'h0);
      check_val("s3_valid", bus.if_valid, 0);
    end
    check_val("s3_req", bus.imem_req, 1);
    check_val("s3_addr", bus.imem_addr, 32'h0000_0100);
    run_fetch(32'h0000_0100);

    // Redirect in REQ without grant.
    tick(1'b0, 32'h0);
    check_val("s4_addr_a", bus.imem_addr, 32'h104);
    tick(1'b1, 32'h40);
    check_val("s4_req_b", bus.imem_req, 1);
    check_val("s4_addr_b", bus.imem_addr, 32'h40);
    tick(1'b0, 32'h0);
    check_val("s4_addr_c", bus.imem_addr, 32'h40);
    run_fetch(32'h40);

    // Redirect coinciding with grant: that response is discarded.
    exp_addr.push_back(32'h44);
    gnt_en = 1'b1;
    tick(1'b1, 32'h83);
    gnt_en = 1'b0;
    check_val("s5_gnt", exp_addr.size(), 0);
    tick(1'b0, 32'h0);
    check_val("s5_valid", bus.if_valid, 0);
    check_val("s5_req", bus.imem_req, 1);
    check_val("s5_addr", bus.imem_addr, 32'h80);
    run_fetch(32'h80);

    // Redirect in HOLD with same-cycle transfer.
    lat      = 1;
    ready_en = 1'b0;
    exp_addr.push_back(32'h84);
    gnt_en = 1'b1;
    for (int i = 0; i < 10 && exp_addr.size() != 0; i++) tick(1'b0, 32'h0);
    gnt_en = 1'b0;
    for (int i = 0; i < 10 && !bus.if_valid; i++) tick(1'b0, 32'h0);
    check_val("s6_hold", bus.if_valid, 1);
    exp_xfer.push_back('{32'h84, mem_fn(32'h84)});
    ready_en = 1'b1;
    tick(1'b1, 32'h200);
    check_val("s6_consumed", exp_xfer.size(), 0);
    check_val("s6_valid", bus.if_valid, 0);
    check_val("s6_req", bus.imem_req, 1);
    check_val("s6_addr", bus.imem_addr, 32'h200);
    run_fetch(32'h200);

    // Address wrap at the top of memory.
    tick(1'b1, 32'hFFFF_FFFF);
    check_val("s7_align", bus.imem_addr, 32'hFFFF_FFFC);
    run_fetch(32'hFFFF_FFFC);
    check_val("s7_wrap", bus.imem_addr, 32'h0);
    check_val("s7_req", bus.imem_req, 1);

    // Stray rvalid in REQ is ignored.
    stray_rv = 1'b1;
    tick(1'b0, 32'h0);
    check_val("s8_valid", bus.if_valid, 0);
    check_val("s8_req", bus.imem_req, 1);
    check_val("s8_pc", bus.if_pc, 32'hFFFF_FFFC);
    check_val("s8_inst", bus.if_inst, mem_fn(32'hFFFF_FFFC));

    // Reset in WAIT; stale response lands in REQ and is ignored.
    tick(1'b1, 32'h300);
    exp_addr.push_back(32'h300);
    lat    = 4;
    gnt_en = 1'b1;
    for (int i = 0; i < 10 && exp_addr.size() != 0; i++) tick(1'b0, 32'h0);
    gnt_en = 1'b0;
    check_val("s9_gnt", exp_addr.size(), 0);
    tick(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick(1'b0, 32'h0);
    rst_n = 1'b1;
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    check_val("s9_stale_seen", pend, 0);
    check_val("s9_valid", bus.if_valid, 0);
    check_val("s9_req", bus.imem_req, 1);
    check_val("s9_addr", bus.imem_addr, 32'h0);
    check_val("s9_inst", bus.if_inst, 32'h0000_0013);
    run_fetch(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
